// File: rtl/water_dispenser_pkg.sv
// Shared definitions for the water dispenser amount path.
// The keypad entry block uses the same width and maximum constants as the dispense controller.
package water_dispenser_pkg;

    localparam int DEFAULT_AMOUNT_WIDTH   = 14;
    localparam int DEFAULT_MAXIMUM_AMOUNT = 9999;
    localparam int DEFAULT_ML_PER_PULSE   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } dispense_state_t;

endpackage

// File: rtl/flow_pulse_sync.sv
// Brings the raw flow-meter pulse into the clock domain with a two-flop synchronizer.
// Turns each rising edge into a one-clock count-enable pulse.
// The count lands on the third clock edge after flow_pulse rises.
module flow_pulse_sync (
    input  logic clock,
    input  logic reset,
    input  logic flow_pulse,
    output logic count_pulse
);

    logic sync_first;
    logic sync_second;
    logic sync_previous;

    // Synchronizer chain plus a delayed copy for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_first    <= 1'b0;
            sync_second   <= 1'b0;
            sync_previous <= 1'b0;
        end else begin
            sync_first    <= flow_pulse;
            sync_second   <= sync_first;
            sync_previous <= sync_second;
        end
    end

    assign count_pulse = sync_second & ~sync_previous;

endmodule

// File: rtl/dispense_controller.sv
// Dispense controller: latches a confirmed amount, opens the valve, and counts flow-meter pulses
// until that volume has been delivered.
// Optional no-flow watchdog with a FAULT state is enabled by defining DISPENSE_TIMEOUT_EN.
module dispense_controller
    import water_dispenser_pkg::*;
#(
    parameter int AMOUNT_WIDTH   = DEFAULT_AMOUNT_WIDTH,
    parameter int MAXIMUM_AMOUNT = DEFAULT_MAXIMUM_AMOUNT,
    parameter int ML_PER_PULSE   = DEFAULT_ML_PER_PULSE,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [AMOUNT_WIDTH-1:0] requested_amount,
    input  logic                    start,
    input  logic                    cancel,
    input  logic                    flow_pulse,
    output logic                    valve_open,
    output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
    output logic                    busy,
    output logic                    done,
    output logic                    fault
);

    dispense_state_t         state;
    logic [AMOUNT_WIDTH-1:0] target_amount;
    logic                    count_pulse;
    logic                    request_valid;
    logic [AMOUNT_WIDTH:0]   raw_sum;
    logic [AMOUNT_WIDTH-1:0] next_amount;

    flow_pulse_sync u_flow_pulse_sync (
        .clock       (clock),
        .reset       (reset),
        .flow_pulse  (flow_pulse),
        .count_pulse (count_pulse)
    );

    assign request_valid = (requested_amount != '0) &&
                           (requested_amount <= AMOUNT_WIDTH'(MAXIMUM_AMOUNT));

    // Saturating accumulate of one flow-meter step onto the running total
    always_comb begin
        raw_sum     = {1'b0, dispensed_amount} + (AMOUNT_WIDTH + 1)'(ML_PER_PULSE);
        next_amount = raw_sum[AMOUNT_WIDTH] ? '1 : raw_sum[AMOUNT_WIDTH-1:0];
    end

`ifdef DISPENSE_TIMEOUT_EN
    localparam int NO_FLOW_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [NO_FLOW_WIDTH-1:0] no_flow_count;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign fault = 1'b0;
`endif

    // Main FSM: valve control, accumulator, done pulse and optional no-flow watchdog
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            valve_open       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            dispensed_amount <= '0;
            target_amount    <= '0;
`ifdef DISPENSE_TIMEOUT_EN
            fault            <= 1'b0;
            no_flow_count    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    valve_open <= 1'b0;
                    busy       <= 1'b0;
                    if (start && request_valid) begin
                        target_amount    <= requested_amount;
                        dispensed_amount <= '0;
                        valve_open       <= 1'b1;
                        busy             <= 1'b1;
                        state            <= FILL;
`ifdef DISPENSE_TIMEOUT_EN
                        no_flow_count    <= '0;
`endif
                    end
                end
                FILL: begin
                    if (count_pulse) begin
                        dispensed_amount <= next_amount;
                    end
                    if (cancel) begin
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (count_pulse && (next_amount >= target_amount)) begin
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
`ifdef DISPENSE_TIMEOUT_EN
                    else if (count_pulse) begin
                        no_flow_count <= '0;
                    end else if (no_flow_count == NO_FLOW_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        state      <= FAULT;
                    end else begin
                        no_flow_count <= no_flow_count + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                FAULT: begin
`ifdef DISPENSE_TIMEOUT_EN
                    if (cancel) begin
                        fault <= 1'b0;
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_controller.sv
// Directed testbench for dispense_controller.
// Uses hand-computed expectations with ML_PER_PULSE = 5 and TIMEOUT_CYCLES = 100.
module tb_dispense_controller;

    logic        clock;
    logic        reset;
    logic [13:0] requested_amount;
    logic        start;
    logic        cancel;
    logic        flow_pulse;
    logic        valve_open;
    logic [13:0] dispensed_amount;
    logic        busy;
    logic        done;
    logic        fault;

    int checks;
    int failures;
    int done_count;

    dispense_controller #(
        .AMOUNT_WIDTH   (14),
        .MAXIMUM_AMOUNT (9999),
        .ML_PER_PULSE   (5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .requested_amount (requested_amount),
        .start            (start),
        .cancel           (cancel),
        .flow_pulse       (flow_pulse),
        .valve_open       (valve_open),
        .dispensed_amount (dispensed_amount),
        .busy             (busy),
        .done             (done),
        .fault            (fault)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Tally done pulses, sampled mid-cycle
    always @(negedge clock) begin
        if (done) done_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present an amount with a one-cycle start strobe; returns on the falling edge after it was taken
    task automatic applyStimulus(input logic [13:0] amount);
        @(negedge clock);
        requested_amount = amount;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // One flow-meter pulse; returns on the falling edge just after the resulting count edge
    task automatic pulseFlow();
        @(negedge clock);
        flow_pulse = 1'b1;
        repeat (2) @(negedge clock);
        flow_pulse = 1'b0;
        @(negedge clock);
    endtask

    task automatic strobeCancel();
        @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        done_count = 0;
        reset = 1'b1;
        requested_amount = '0;
        start = 1'b0;
        cancel = 1'b0;
        flow_pulse = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_valve", valve_open, 0);
        checkOutput("reset_dispensed", dispensed_amount, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_fault", fault, 0);
        reset = 1'b0;

        // Flow edges while idle are not counted
        pulseFlow();
        checkOutput("idle_flow_ignored", dispensed_amount, 0);

        // Scenario: 20 mL in four pulses
        applyStimulus(14'd20);
        checkOutput("s1_valve_open", valve_open, 1);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_dispensed_start", dispensed_amount, 0);
        pulseFlow();
        checkOutput("s1_count1", dispensed_amount, 5);
        pulseFlow();
        checkOutput("s1_count2", dispensed_amount, 10);
        pulseFlow();
        checkOutput("s1_count3", dispensed_amount, 15);
        checkOutput("s1_valve_still_open", valve_open, 1);
        checkOutput("s1_no_done_yet", done, 0);
        pulseFlow();
        checkOutput("s1_count4", dispensed_amount, 20);
        checkOutput("s1_valve_closed", valve_open, 0);
        checkOutput("s1_done_pulse", done, 1);
        checkOutput("s1_busy_low", busy, 0);
        @(negedge clock);
        checkOutput("s1_done_single", done, 0);
        checkOutput("s1_done_count", done_count, 1);

        // Scenario: 12 mL overshoots to 15
        applyStimulus(14'd12);
        checkOutput("s2_dispensed_cleared", dispensed_amount, 0);
        pulseFlow();
        pulseFlow();
        pulseFlow();
        checkOutput("s2_overshoot", dispensed_amount, 15);
        checkOutput("s2_done", done, 1);
        checkOutput("s2_valve_closed", valve_open, 0);
        pulseFlow();
        checkOutput("s2_extra_pulse_ignored", dispensed_amount, 15);
        checkOutput("s2_done_count", done_count, 2);

        // Scenario: cancel mid-fill holds the count
        applyStimulus(14'd50);
        pulseFlow();
        pulseFlow();
        checkOutput("s3_partial", dispensed_amount, 10);
        strobeCancel();
        checkOutput("s3_valve_closed", valve_open, 0);
        checkOutput("s3_busy_low", busy, 0);
        checkOutput("s3_dispensed_held", dispensed_amount, 10);
        checkOutput("s3_no_done", done_count, 2);

        // Scenario: out-of-range requests are ignored
        applyStimulus(14'd0);
        checkOutput("s4_zero_valve", valve_open, 0);
        checkOutput("s4_zero_busy", busy, 0);
        checkOutput("s4_zero_dispensed", dispensed_amount, 10);
        applyStimulus(14'd10000);
        checkOutput("s4_over_valve", valve_open, 0);
        checkOutput("s4_over_busy", busy, 0);
        checkOutput("s4_over_dispensed", dispensed_amount, 10);

        // The maximum request is accepted
        applyStimulus(14'd9999);
        checkOutput("max_accepted_busy", busy, 1);
        checkOutput("max_accepted_cleared", dispensed_amount, 0);
        applyStimulus(14'd20);
        checkOutput("start_in_fill_ignored", dispensed_amount, 0);
        strobeCancel();
        checkOutput("max_cancel_valve", valve_open, 0);

        // Cancel coinciding with the target-reaching count: cancel wins, count still updates
        applyStimulus(14'd5);
        @(negedge clock);
        flow_pulse = 1'b1;
        @(negedge clock);
        @(negedge clock);
        flow_pulse = 1'b0;
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        checkOutput("race_count_updated", dispensed_amount, 5);
        checkOutput("race_valve_closed", valve_open, 0);
        checkOutput("race_busy_low", busy, 0);
        checkOutput("race_no_done", done_count, 2);
        @(negedge clock);
        checkOutput("race_idle_done_low", done, 0);

`ifdef DISPENSE_TIMEOUT_EN
        // Watchdog: no flow for 100 clocks drives FAULT
        applyStimulus(14'd20);
        repeat (99) @(negedge clock);
        checkOutput("wd_before_limit_fault", fault, 0);
        checkOutput("wd_before_limit_valve", valve_open, 1);
        @(negedge clock);
        checkOutput("wd_fault", fault, 1);
        checkOutput("wd_valve_closed", valve_open, 0);
        checkOutput("wd_busy_low", busy, 0);
        applyStimulus(14'd20);
        checkOutput("wd_start_ignored_fault", fault, 1);
        checkOutput("wd_start_ignored_valve", valve_open, 0);
        strobeCancel();
        checkOutput("wd_cancel_clears", fault, 0);
        applyStimulus(14'd20);
        checkOutput("wd_restart_busy", busy, 1);
        strobeCancel();
`else
        // Without the watchdog a silent meter just keeps the valve open
        applyStimulus(14'd20);
        repeat (150) @(negedge clock);
        checkOutput("nowd_valve_open", valve_open, 1);
        checkOutput("nowd_fault_low", fault, 0);
        strobeCancel();
`endif

        // Asynchronous reset mid-fill takes effect between clock edges
        applyStimulus(14'd20);
        pulseFlow();
        checkOutput("s5_pre_reset_count", dispensed_amount, 5);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s5_valve", valve_open, 0);
        checkOutput("s5_busy", busy, 0);
        checkOutput("s5_dispensed", dispensed_amount, 0);
        checkOutput("s5_done", done, 0);
        checkOutput("s5_fault", fault, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("s5_stays_idle", valve_open, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
